// File: rtl/sort_pkg.sv
// Shared types and sizing for the row-array sort/read slice.
// Build option: define SORT_RDR_REVERSE_EN to drain rows from NUM_ROWS-1 down to 0.
package sort_pkg;

    localparam int NUM_ROWS  = 8;
    localparam int WIDTH     = 8;
    localparam int ROW_IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef logic [NUM_ROWS-1:0]  t_addr;
    typedef logic [WIDTH-1:0]     t_data;
    typedef logic [ROW_IDX_W-1:0] t_row_idx;

    localparam t_row_idx LAST_ROW_IDX = t_row_idx'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } t_rdr_state;

    // One-hot row select for a binary row index.
    function automatic t_addr row_onehot(input t_row_idx idx);
        t_addr a;
        a      = '0;
        a[idx] = 1'b1;
        return a;
    endfunction

endpackage

// File: rtl/sort_rdr_fifo2.sv
// Two-entry {data, last} FIFO used as the reader's output skid buffer.
// Only pointers and occupancy are reset; payload slots are qualified by occupancy.
module sort_rdr_fifo2
    import sort_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  t_data      push_data,
    input  logic       push_last,
    input  logic       pop,
    output t_data      head_data,
    output logic       head_last,
    output logic       empty,
    output logic       full,
    output logic [1:0] count
);

    t_data      data_q [2];
    logic       last_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign empty     = (count_q == 2'd0);
    assign full      = (count_q == 2'd2);
    assign count     = count_q;
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload write into the tail slot; the head slot is never touched by a push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            data_q[wr_ptr_q] <= push_data;
            last_q[wr_ptr_q] <= push_last;
        end
    end

endmodule

// File: rtl/sorted_row_reader.sv
// Drains the sorted row array through the one-hot row-select port and streams
// each word out on a valid/ready interface with full backpressure.
// Build option: SORT_RDR_REVERSE_EN reads rows NUM_ROWS-1 down to 0.
module sorted_row_reader
    import sort_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  start,
    output logic  busy,
    output logic  rd_en,
    output t_addr rd_addr,
    input  t_data rd_data,
    output logic  out_valid,
    input  logic  out_ready,
    output t_data out_data,
    output logic  out_last,
    output logic  done
);

    t_rdr_state state_q, state_d;
    t_row_idx   row_idx_q, row_idx_d;
    t_row_idx   addr_idx;
    logic       inflight_q;
    logic       inflight_last_q;
    logic       done_q, done_d;
    logic       read_last;

    logic       fifo_empty;
    logic       fifo_full;
    logic [1:0] fifo_count;
    t_data      head_data;
    logic       head_last;

    logic       pop;
    logic [2:0] credit_used;
    logic       credit_ok;

    // The final row of a drain is always the last counter value; only the
    // mapping from counter to physical row changes between builds.
    assign read_last = (row_idx_q == LAST_ROW_IDX);
`ifdef SORT_RDR_REVERSE_EN
    assign addr_idx = LAST_ROW_IDX - row_idx_q;
`else
    assign addr_idx = row_idx_q;
`endif

    // A read may issue only if its word is guaranteed a FIFO slot when it
    // returns: occupancy plus the word in flight, less a word leaving now.
    assign pop         = out_valid & out_ready;
    assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_ok   = (credit_used < (3'd2 + {2'b00, pop})) & ~(fifo_full & ~pop);

    assign busy    = (state_q != IDLE);
    assign rd_addr = rd_en ? row_onehot(addr_idx) : '0;
    assign done    = done_q;

    // Next-state, read strobe and row counter advance.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        rd_en     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = READ;
                    row_idx_d = '0;
                end
            end
            READ: begin
                if (credit_ok) begin
                    rd_en = 1'b1;
                    if (read_last) state_d   = DRAIN;
                    else           row_idx_d = row_idx_q + t_row_idx'(1);
                end
            end
            DRAIN: begin
                if (pop && out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM, row counter, in-flight read tracking and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            row_idx_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            row_idx_q       <= row_idx_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en & read_last;
            done_q          <= done_d;
        end
    end

    // Array words land in the FIFO in the cycle they are valid; a cleared
    // in-flight flag after reset drops any word still on its way back.
    sort_rdr_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (rd_data),
        .push_last (inflight_last_q),
        .pop       (pop),
        .head_data (head_data),
        .head_last (head_last),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? '0 : head_data;
    assign out_last  = ~fifo_empty & head_last;

endmodule

// File: tb/tb_sorted_row_reader.sv
// Self-checking bench for sorted_row_reader: behavioural array responder plus
// an expected-order reference model driven from a linear directed sequence.
`timescale 1ns/1ps
module tb_sorted_row_reader;
    import sort_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  start;
    logic  busy;
    logic  rd_en;
    t_addr rd_addr;
    t_data rd_data;
    logic  out_valid;
    logic  out_ready;
    t_data out_data;
    logic  out_last;
    logic  done;

    int tests = 0;
    int fails = 0;

    // Array contents and reference-model state.
    t_data mem [NUM_ROWS];
    bit    active;
    bit    done_due;
    int    reads;
    int    hs;
    int    rel;
    int    first_valid_rel;
    int    last_hs_rel;
    int    done_rel;
    bit    prev_stall;
    t_data prev_data;
    logic  prev_last;

    always #5 clk = ~clk;

    sorted_row_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done)
    );

    // Physical row delivered as the k-th word of a drain.
    function automatic int row_of(input int k);
`ifdef SORT_RDR_REVERSE_EN
        return NUM_ROWS - 1 - k;
`else
        return k;
`endif
    endfunction

    function automatic t_addr exp_addr(input int k);
        t_addr a;
        a = '0;
        a[row_of(k)] = 1'b1;
        return a;
    endfunction

    function automatic int addr_row(input t_addr a);
        int r;
        r = -1;
        if ($countones(a) == 1)
            for (int i = 0; i < NUM_ROWS; i++) if (a[i]) r = i;
        return r;
    endfunction

    // Row array with one-cycle read latency; junk on the bus when idle.
    always @(posedge clk) begin
        if (rd_en && addr_row(rd_addr) >= 0) rd_data <= mem[addr_row(rd_addr)];
        else                                 rd_data <= t_data'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance.
    task automatic cyc(input logic s, input logic r);
        bit last_hs;
        bit accept;
        start     = s;
        out_ready = r;
        #1;
        check("busy", 32'(busy), 32'(active));
        check("done", 32'(done), 32'(done_due));
        if (done && done_rel < 0) done_rel = rel;
        if (rd_en) begin
            check("read_in_range", 32'(reads < NUM_ROWS), 32'd1);
            if (reads < NUM_ROWS) check("rd_addr", 32'(rd_addr), 32'(exp_addr(reads)));
            reads++;
            check("credit", 32'((reads - hs) <= (2 + ((out_valid && out_ready) ? 1 : 0))), 32'd1);
        end
        if (prev_stall) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
            check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && first_valid_rel < 0) first_valid_rel = rel;
        last_hs = 1'b0;
        if (out_valid && out_ready) begin
            check("word_in_range", 32'(hs < NUM_ROWS), 32'd1);
            if (hs < NUM_ROWS) begin
                check("out_data", 32'(out_data), 32'(mem[row_of(hs)]));
                check("out_last", 32'(out_last), 32'(hs == NUM_ROWS - 1));
            end
            if (hs == NUM_ROWS - 1) begin
                last_hs     = 1'b1;
                last_hs_rel = rel;
            end
            hs++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        accept     = s && !active;
        done_due   = last_hs;
        if (last_hs) active = 1'b0;
        if (accept) begin
            active          = 1'b1;
            reads           = 0;
            hs              = 0;
            rel             = 0;
            first_valid_rel = -1;
            last_hs_rel     = -1;
            done_rel        = -1;
        end
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        active     = 1'b0;
        done_due   = 1'b0;
        prev_stall = 1'b0;
        reads      = 0;
        hs         = 0;
    endtask

    function automatic logic ready_for(input int mode, input int i);
        case (mode)
            0:       return 1'b1;
            1:       return (i % 2) == 0;
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Keep clocking until the done pulse is seen, within a cycle budget.
    task automatic finish_drain(input int mode, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (done_rel >= 0) break;
            cyc(1'b0, ready_for(mode, i));
        end
        check("drain_done", 32'(done_rel >= 0), 32'd1);
        check("drain_words", 32'(hs), 32'(NUM_ROWS));
    endtask

    task automatic fill_random();
        for (int i = 0; i < NUM_ROWS; i++) mem[i] = t_data'($urandom);
    endtask

    initial begin
        start     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        done_rel  = -1;
        for (int i = 0; i < NUM_ROWS; i++) mem[i] = t_data'((i + 1) * 16);
        #2;
        do_reset();
        cyc(1'b0, 1'b1);

        // Full-rate drain of the ascending pattern; check cycle-exact latency.
        cyc(1'b1, 1'b1);
        finish_drain(0, 40);
        check("first_valid_cycle", 32'(first_valid_rel), 32'd3);
        check("last_hs_cycle", 32'(last_hs_rel), 32'(NUM_ROWS + 2));
        check("done_cycle", 32'(done_rel), 32'(NUM_ROWS + 3));
        cyc(1'b0, 1'b1);

        // Alternating ready.
        cyc(1'b1, 1'b1);
        finish_drain(1, 80);
        cyc(1'b0, 1'b0);

        // Long stall right after start: only two reads may be outstanding.
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
        check("stall_reads", 32'(reads), 32'd2);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(mem[row_of(0)]));
        finish_drain(0, 40);
        cyc(1'b0, 1'b1);

        // Reset in the middle of a drain, then a fresh full drain.
        fill_random();
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1);
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end
        fill_random();
        cyc(1'b1, 1'b1);
        finish_drain(0, 40);
        cyc(1'b0, 1'b1);

        // Start while busy is ignored; start with done begins a new drain.
        cyc(1'b1, 1'b1);
        for (int i = 1; i <= NUM_ROWS + 2; i++) cyc(i == 4, 1'b1);
        check("coincident_done", 32'(done), 32'd1);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        check("restart_reads", 32'(reads), 32'd1);
        finish_drain(0, 40);
        cyc(1'b0, 1'b1);

        // Randomised contents under random backpressure.
        for (int n = 0; n < 4; n++) begin
            fill_random();
            cyc(1'b1, 1'b1);
            finish_drain(2, 200);
            cyc(1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
